// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD character fetcher
//
// Purpose : FSM state encoding, display geometry and character formatting
//           used by lcd_char_fetch.
// Contents: state_t            - fetch FSM states
//           LINE_LEN           - characters per LCD line (row 1 starts here)
//           SPACE_CHAR         - ASCII space
//           DEFAULT_NUM_CHARS  - default characters per frame
//           present_char()     - maps an assembled byte to the presented byte
// Options : LCD_FETCH_NULL_SPACE_EN - when defined, a stored 8'h00 is shown
//           as a space; otherwise bytes pass through unchanged.

package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_LO = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int          LINE_LEN          = 16;
  localparam logic [7:0]  SPACE_CHAR        = 8'h20;
  localparam int          DEFAULT_NUM_CHARS = 32;

  function automatic logic [7:0] present_char(input logic [7:0] raw);
`ifdef LCD_FETCH_NULL_SPACE_EN
    // Unwritten text RAM reads as zero; show it blank rather than as a glyph.
    return (raw == 8'h00) ? SPACE_CHAR : raw;
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/lcd_char_fetch.sv
// rtl/lcd_char_fetch.sv - fetches a frame of 8-bit characters from a 4-bit BRAM
//
// Purpose : On start, reads NUM_CHARS characters (two nibbles each, low nibble
//           first) from a 4k x 4 BRAM starting at BASE_ADDR and hands them one
//           by one to an LCD writer over a valid/ready handshake.
// Params  : BASE_ADDR  - nibble address of character 0 (12-bit, wraps)
//           NUM_CHARS  - characters per frame, 1..64
// Ports   : clk, reset           - clock, synchronous active-high reset
//           start                - frame request (only seen when idle)
//           bram_addr/en/do      - BRAM read port (1-cycle read latency)
//           bram_we/ssr/di       - unused write side, held at 0
//           char_data/valid/ready- character stream to the LCD writer
//           char_index, char_row - position of the presented character
//           busy, done           - frame in progress / end-of-frame pulse
// Options : LCD_FETCH_NULL_SPACE_EN (see lcd_pkg) - present 8'h00 as a space.

module lcd_char_fetch
  import lcd_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          NUM_CHARS = DEFAULT_NUM_CHARS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] bram_addr,
  output logic        bram_en,
  output logic        bram_we,
  output logic        bram_ssr,
  output logic [3:0]  bram_di,
  input  logic [3:0]  bram_do,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [5:0]  char_index,
  output logic        char_row,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_INDEX = 6'(NUM_CHARS - 1);
  localparam logic [5:0] ROW1_START = 6'(LINE_LEN);

  state_t      state, state_next;
  logic [3:0]  nib_lo, nib_hi;
  logic [11:0] char_base;
  logic        handshake;

  // 12-bit sum wraps naturally from 4095 back to 0.
  assign char_base = BASE_ADDR + {5'd0, char_index, 1'b0};
  assign handshake = (state == ST_PRESENT) && char_valid && char_ready;

  assign bram_we  = 1'b0;
  assign bram_ssr = 1'b0;
  assign bram_di  = 4'd0;

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign char_row = (char_index >= ROW1_START);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bram_en    = 1'b0;
    bram_addr  = 12'd0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        bram_en    = 1'b1;
        bram_addr  = char_base;
        state_next = ST_ADDR_HI;
      end
      ST_ADDR_HI: begin
        bram_en    = 1'b1;
        bram_addr  = char_base + 12'd1;
        state_next = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          state_next = (char_index == LAST_INDEX) ? ST_DONE : ST_ADDR_LO;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      char_index <= 6'd0;
      nib_lo     <= 4'd0;
      nib_hi     <= 4'd0;
      char_data  <= 8'd0;
      char_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            char_index <= 6'd0;
          end
        end
        ST_ADDR_HI: begin
          nib_lo <= bram_do;
        end
        ST_DATA_HI: begin
          nib_hi <= bram_do;
        end
        ST_PRESENT: begin
          // First PRESENT cycle loads the output register; char_data is then
          // held untouched until the writer accepts it.
          if (!char_valid) begin
            char_data  <= present_char({nib_hi, nib_lo});
            char_valid <= 1'b1;
          end else if (char_ready) begin
            char_valid <= 1'b0;
            if (char_index != LAST_INDEX) begin
              char_index <= char_index + 6'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_fetch.sv
// tb/tb_lcd_char_fetch.sv - scoreboard bench for lcd_char_fetch
//
// Purpose : Drives random and directed frames into lcd_char_fetch with a
//           1-cycle-latency 4-bit BRAM model; a monitor compares every
//           presented character against a queue filled from memory contents.
// Options : honours LCD_FETCH_NULL_SPACE_EN for the expected null mapping.

module tb_lcd_char_fetch;

  localparam logic [11:0] BASE = 12'hFFE;
  localparam int          NUM  = 32;

  typedef struct {
    logic [7:0] data;
    logic [5:0] index;
    logic       row;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bram_addr;
  logic        bram_en, bram_we, bram_ssr;
  logic [3:0]  bram_di;
  logic [3:0]  bram_do;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic [5:0]  char_index;
  logic        char_row;
  logic        busy, done;

  logic [3:0]  mem [4096];
  exp_t        exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          have_hs = 0;
  bit          prev_valid = 0;

  lcd_char_fetch #(.BASE_ADDR(BASE), .NUM_CHARS(NUM)) dut (
    .clk(clk), .reset(reset), .start(start),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_ssr(bram_ssr), .bram_di(bram_di), .bram_do(bram_do),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_index(char_index), .char_row(char_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_en) bram_do <= mem[bram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] ref_char(input int i);
    int a;
    logic [7:0] b;
    a = (int'(BASE) + 2 * i) % 4096;
    b = {mem[(a + 1) % 4096], mem[a]};
`ifdef LCD_FETCH_NULL_SPACE_EN
    if (b == 8'h00) b = 8'h20;
`endif
    return b;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < NUM; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        mem[(int'(BASE) + 2 * i) % 4096]     = 4'd0;
        mem[(int'(BASE) + 2 * i + 1) % 4096] = 4'd0;
      end
    end
  endtask

  task automatic start_frame();
    exp_t e;
    for (int i = 0; i < NUM; i++) begin
      e.data  = ref_char(i);
      e.index = 6'(i);
      e.row   = (i / 16) != 0;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd_ready);
    int d0;
    int ok;
    d0 = done_cnt;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
      char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    chk("frame_done_seen", ok, 1);
    chk("busy_falls_with_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("done_count_per_frame", done_cnt, d0 + 1);
    chk("idle_after_frame", busy, 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      have_hs    = 0;
      prev_valid = 0;
    end else begin
      chk("bram_write_side_zero", {bram_we, bram_ssr, bram_di}, 0);
      if (char_valid) begin
        if (!prev_valid && have_hs) chk("gap_after_handshake", cyc - hs_cyc, 4);
        chk("bram_en_in_present", bram_en, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_char", 1, 0);
        end else begin
          chk("char_data", char_data, exp_q[0].data);
          chk("char_index", char_index, exp_q[0].index);
          chk("char_row", char_row, exp_q[0].row);
          if (char_ready) begin
            void'(exp_q.pop_front());
            hs_cyc  = cyc + 1;
            have_hs = 1;
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("queue_empty_at_done", exp_q.size(), 0);
        have_hs = 0;
      end
      prev_valid = char_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int ok;
    logic [7:0] snap_d;
    logic [5:0] snap_i;

    reset = 1'b1;
    start = 1'b0;
    char_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_valid", char_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_char_index", char_index, 0);
    chk("rst_char_data", char_data, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame A: directed nibbles 1,4,2,4 (with wrap at 0xFFF), a null byte, ready=1
    fill_mem();
    mem[12'hFFE] = 4'd1; mem[12'hFFF] = 4'd4;
    mem[12'h000] = 4'd2; mem[12'h001] = 4'd4;
    mem[12'h002] = 4'd0; mem[12'h003] = 4'd0;
    char_ready = 1'b1;
    start_frame();
    lat = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      lat++;
      if (char_valid) break;
    end
    chk("first_valid_latency", lat, 4);
    chk("first_char_0x41", char_data, 8'h41);
    run_to_done(1'b0);

    // Frame B: random data, 10-cycle stall on the first character, random ready
    fill_mem();
    char_ready = 1'b0;
    start_frame();
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (char_valid) begin
        ok = 1;
        break;
      end
    end
    chk("stall_valid_seen", ok, 1);
    snap_d = char_data;
    snap_i = char_index;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_valid_held", char_valid, 1);
      chk("stall_data_held", char_data, snap_d);
      chk("stall_index_held", char_index, snap_i);
      chk("stall_bram_en_low", bram_en, 0);
    end
    run_to_done(1'b1);

    // Frame C: reset mid-frame at index 5
    fill_mem();
    char_ready = 1'b1;
    start_frame();
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (char_valid && char_index == 6'd5) begin
        ok = 1;
        break;
      end
    end
    chk("reached_index_5", ok, 1);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_char_valid", char_valid, 0);
    chk("abort_char_index", char_index, 0);
    chk("abort_char_row", char_row, 0);
    chk("abort_char_data", char_data, 0);
    chk("abort_bram_en", bram_en, 0);
    chk("abort_bram_addr", bram_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_stays_idle", busy, 0);

    // Frame D and E: fresh random frames restart from index 0
    for (int f = 0; f < 2; f++) begin
      fill_mem();
      char_ready = 1'b0;
      start_frame();
      run_to_done(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
